// File: rtl/lag_input_buffer_pkg.sv
// Shared flit definitions for the router datapath and its credit logic.
// DEFAULT_DEPTH is also the sender's initial credit count, so both ends agree.
package lag_input_buffer_pkg;

    localparam int DATA_W        = 32;
    localparam int DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic valid;
        logic tail;
    } flit_ctrl_t;

    typedef struct packed {
        flit_ctrl_t              control;
        logic [DATA_W-1:0]       data;
    } flit_t;

endpackage

// File: rtl/lag_wrap_ptr.sv
// Modulo-depth pointer with increment enable; wraps by explicit compare so
// any depth >= 2 works, not only powers of two.
module lag_wrap_ptr #(
    parameter  int depth = 4,
    localparam int ptr_w = $clog2(depth)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [ptr_w-1:0] ptr
);

    localparam logic [ptr_w-1:0] LAST = ptr_w'(depth - 1);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + ptr_w'(1);
        end
    end

endmodule

// File: rtl/lag_input_buffer.sv
// Receive-side flit FIFO for one router input port; returns one credit per pop.
// No ready toward the channel: the upstream sender only transmits with a credit.
module lag_input_buffer
    import lag_input_buffer_pkg::*;
#(
    parameter  int depth = DEFAULT_DEPTH,
    localparam int cnt_w = $clog2(depth + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  flit_t            data_in,
    output flit_t            data_out,
    output logic             out_valid,
    input  logic             deq,
    output logic             credit_out,
    output logic [cnt_w-1:0] occupancy,
    output logic             overflow_err
);

    localparam int ptr_w = $clog2(depth);

    flit_t            mem [depth];
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic             full;
    logic             do_deq;
    logic             do_wr;
    logic             bad_wr;

    assign full      = (occupancy == cnt_w'(depth));
    assign out_valid = (occupancy != '0);
    assign do_deq    = deq && out_valid;
    // A full buffer still takes a flit when the head leaves in the same cycle.
    assign do_wr     = data_in.control.valid && (!full || do_deq);
    assign bad_wr    = data_in.control.valid && full && !do_deq;

    assign data_out  = out_valid ? mem[rd_ptr] : '0;

    lag_wrap_ptr #(.depth(depth)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (do_wr),
        .ptr   (wr_ptr)
    );

    lag_wrap_ptr #(.depth(depth)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (do_deq),
        .ptr   (rd_ptr)
    );

    // NOTE: the storage array has no reset; data_out is masked by out_valid,
    // so stale slot contents are never observable.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy    <= '0;
            credit_out   <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            credit_out <= do_deq;
            if (bad_wr) begin
                overflow_err <= 1'b1;
            end
            case ({do_wr, do_deq})
                2'b10:   occupancy <= occupancy + cnt_w'(1);
                2'b01:   occupancy <= occupancy - cnt_w'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule
